// File: rtl/majority_sampler.sv
// majority_sampler: five-point bit-period oversampler feeding the majority voter; define MAJ_SAMPLER_SYNC_EN for a 2-flop din synchronizer
module majority_sampler #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SPACING = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       align,
  input  logic       din,
  output logic [4:0] samples,
  output logic       samples_valid,
  input  logic       samples_ready,
  output logic       overrun
);
  localparam int cw = $clog2(CLKS_PER_BIT);
  localparam int mid = CLKS_PER_BIT / 2;
  localparam logic [cw-1:0] last = cw'(CLKS_PER_BIT - 1);
  logic [cw-1:0] cnt;
  logic [4:0] sh;
  logic line;
  logic run;
  logic done;
`ifdef MAJ_SAMPLER_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk)
    sync <= rst ? 2'b00 : {sync[0], din};
  assign line = sync[1];
`else
  assign line = din;
`endif
  assign run = en && !align;
  assign done = run && cnt == last;
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      sh <= '0;
    end else begin
      cnt <= (cnt == last) ? '0 : cnt + 1'b1;
      for (int k = 0; k < 5; k++)
        if (cnt == cw'(mid + (k - 2) * SPACING)) sh[k] <= line;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      samples <= '0;
      samples_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (done) samples <= sh;
      samples_valid <= done || (samples_valid && !samples_ready);
      if (done && samples_valid && !samples_ready) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_majority_sampler.sv
// tb_majority_sampler: directed scenarios plus randomized run against an edge-history reference model
module tb_majority_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic align = 1'b0;
  logic din = 1'b0;
  logic samples_ready = 1'b0;
  logic [4:0] samples;
  logic samples_valid;
  logic overrun;
  int n_chk = 0;
  int n_fail = 0;
  bit dh [0:8191];
  bit lh [0:8191];
  int e = 0;
  int s = 0;
  int lr = 0;
  logic [4:0] m_samples = '0;
  logic m_valid = 1'b0;
  logic m_ov = 1'b0;
`ifdef MAJ_SAMPLER_SYNC_EN
  localparam int lat = 2;
`else
  localparam int lat = 0;
`endif
  majority_sampler #(.CLKS_PER_BIT(16), .SPACING(2)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .align(align),
    .din(din),
    .samples(samples),
    .samples_valid(samples_valid),
    .samples_ready(samples_ready),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic step();
    logic [4:0] w;
    bit l;
    bit done;
    @(posedge clk);
    done = 1'b0;
    dh[e] = din;
    if (lat == 0) l = din;
    else if (e - lat > lr) l = dh[e - lat];
    else l = 1'b0;
    lh[e] = l;
    if (rst) begin
      m_samples = '0;
      m_valid = 1'b0;
      m_ov = 1'b0;
      s = e + 1;
      lr = e;
    end else begin
      if (!en || align) s = e + 1;
      else if ((e - s) % 16 == 15) begin
        for (int k = 0; k < 5; k++) w[k] = lh[s + 8 + (k - 2) * 2];
        if (m_valid && !samples_ready) m_ov = 1'b1;
        m_samples = w;
        m_valid = 1'b1;
        done = 1'b1;
        s = e + 1;
      end
      if (!done && m_valid && samples_ready) m_valid = 1'b0;
    end
    e++;
    #1;
  endtask
  task automatic do_reset(input logic d, input logic rdy);
    din = d;
    rst = 1'b1;
    en = 1'b1;
    align = 1'b0;
    samples_ready = rdy;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    n_chk++;
    if (samples !== 5'b00000) begin n_fail++; $display("FAIL reset_samples: got %b expected 00000", samples); end
    n_chk++;
    if (samples_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", samples_valid); end
    n_chk++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask
  task automatic test_constant_high();
    do_reset(1'b1, 1'b1);
    for (int n = 1; n <= 48; n++) begin
      step();
      n_chk++;
      if (samples_valid !== (n % 16 == 0)) begin n_fail++; $display("FAIL const_valid edge %0d: got %b expected %b", n, samples_valid, n % 16 == 0); end
      if (n % 16 == 0) begin
        n_chk++;
        if (samples !== 5'b11111) begin n_fail++; $display("FAIL const_samples edge %0d: got %b expected 11111", n, samples); end
      end
    end
    n_chk++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL const_overrun: got %b expected 0", overrun); end
  endtask
  task automatic test_glitch();
    do_reset(1'b1, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      din = (n - 1 == 8 - lat) ? 1'b0 : 1'b1;
      step();
    end
    din = 1'b1;
    n_chk++;
    if (samples_valid !== 1'b1 || samples !== 5'b11011) begin n_fail++; $display("FAIL glitch: got valid %b samples %b expected valid 1 samples 11011", samples_valid, samples); end
  endtask
  task automatic test_backpressure();
    do_reset(1'b1, 1'b0);
    for (int n = 1; n <= 40; n++) begin
      din = (n <= 16) ? 1'b1 : 1'b0;
      step();
      if (n == 16) begin
        n_chk++;
        if (samples !== 5'b11111 || overrun !== 1'b0) begin n_fail++; $display("FAIL bp_first: got samples %b overrun %b expected 11111 0", samples, overrun); end
      end
      if (n == 32) begin
        n_chk++;
        if (samples !== 5'b00000 || samples_valid !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL bp_second: got samples %b valid %b overrun %b expected 00000 1 1", samples, samples_valid, overrun); end
      end
    end
    samples_ready = 1'b1;
    step();
    n_chk++;
    if (overrun !== 1'b1 || samples_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after: got overrun %b valid %b expected 1 0", overrun, samples_valid); end
  endtask
  task automatic test_align_mid();
    do_reset(1'b1, 1'b1);
    for (int n = 0; n < 9; n++) step();
    align = 1'b1;
    step();
    align = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      n_chk++;
      if (samples_valid !== (n == 16)) begin n_fail++; $display("FAIL align_mid_valid edge %0d: got %b expected %b", n, samples_valid, n == 16); end
    end
    n_chk++;
    if (samples !== 5'b11111) begin n_fail++; $display("FAIL align_mid_samples: got %b expected 11111", samples); end
  endtask
  task automatic test_align_end();
    do_reset(1'b0, 1'b1);
    for (int n = 0; n < 15; n++) step();
    align = 1'b1;
    step();
    align = 1'b0;
    n_chk++;
    if (samples_valid !== 1'b0) begin n_fail++; $display("FAIL align_end_suppress: got %b expected 0", samples_valid); end
    din = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      n_chk++;
      if (samples_valid !== (n == 16)) begin n_fail++; $display("FAIL align_end_valid edge %0d: got %b expected %b", n, samples_valid, n == 16); end
    end
    n_chk++;
    if (samples !== 5'b11111) begin n_fail++; $display("FAIL align_end_samples: got %b expected 11111", samples); end
  endtask
  task automatic test_reset_mid();
    do_reset(1'b1, 1'b0);
    for (int n = 0; n < 16; n++) step();
    n_chk++;
    if (samples_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b expected 1", samples_valid); end
    for (int n = 0; n < 7; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (samples !== 5'b00000 || samples_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_cleared: got samples %b valid %b overrun %b expected 00000 0 0", samples, samples_valid, overrun); end
    samples_ready = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      n_chk++;
      if (samples_valid !== (n == 16)) begin n_fail++; $display("FAIL rmid_valid edge %0d: got %b expected %b", n, samples_valid, n == 16); end
    end
  endtask
  task automatic test_random();
    do_reset(1'b0, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 39) != 0);
      align = ($urandom_range(0, 49) == 0);
      din = 1'($urandom_range(0, 1));
      samples_ready = ($urandom_range(0, 3) != 0);
      step();
      n_chk++;
      if (samples !== m_samples) begin n_fail++; $display("FAIL rand_samples cycle %0d: got %b expected %b", n, samples, m_samples); end
      n_chk++;
      if (samples_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid cycle %0d: got %b expected %b", n, samples_valid, m_valid); end
      n_chk++;
      if (overrun !== m_ov) begin n_fail++; $display("FAIL rand_overrun cycle %0d: got %b expected %b", n, overrun, m_ov); end
    end
    rst = 1'b0;
    en = 1'b1;
    align = 1'b0;
  endtask
  initial begin
    test_reset();
    test_constant_high();
    test_glitch();
    test_backpressure();
    test_align_mid();
    test_align_end();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
